// File: rtl/cpu_biu.sv
// Byte-wide bus interface unit: bus clock enable, seg:off address formation,
// data access arbitration and a code prefetch queue. CPU_BIU_PREFETCH_EN enables fill-ahead.
//
// Handshakes: d_req is held by the requester until d_ack (a one-clk pulse) and
// is launched at the first ce tick after it is seen; q_rd pops the head byte
// only when q_valid is high, with the result visible on the next clk.
module cpu_biu #(
  parameter int ADDR_W      = 20,
  parameter int QUEUE_DEPTH = 6,
  parameter int DIV         = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             ce_out,
  output logic [ADDR_W-1:0]                a,
  input  logic [7:0]                       i,
  output logic [7:0]                       o,
  output logic                             w,
  input  logic                             jmp,
  input  logic [15:0]                      cs,
  input  logic [15:0]                      ip,
  output logic [7:0]                       q_data,
  output logic                             q_valid,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] q_count,
  input  logic                             q_rd,
  input  logic                             d_req,
  input  logic                             d_we,
  input  logic [15:0]                      d_seg,
  input  logic [15:0]                      d_off,
  input  logic [7:0]                       d_wdata,
  output logic                             d_ack,
  output logic [7:0]                       d_rdata,
  output logic [1:0]                       dbg_slot
);

  localparam int CW  = $clog2(QUEUE_DEPTH+1);
  localparam int DCW = $clog2(DIV);
`ifdef CPU_BIU_PREFETCH_EN
  localparam int EFF_DEPTH = QUEUE_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DREAD, S_DWRITE} slot_t;

  slot_t                 slot, slot_nxt;
  logic [DCW-1:0]        div_cnt;
  logic                  ce;
  logic [15:0]           fseg, foff;
  logic                  stale;
  logic [8*EFF_DEPTH-1:0] qvec, q_nxt;
  logic [CW-1:0]         widx;
  logic [CW-1:0]         base_count;
  logic [CW:0]           fill;
  logic                  data_busy, launch_data, launch_fetch, push, pop;
  logic [15:0]           launch_seg, launch_off;

  function automatic logic [ADDR_W-1:0] phys(input logic [15:0] seg, input logic [15:0] off);
    logic [31:0] s;
    s = {12'h000, seg, 4'h0} + {16'h0000, off};
    return s[ADDR_W-1:0];
  endfunction

  assign ce       = (div_cnt == DCW'(DIV-1));
  assign ce_out   = ce;
  assign dbg_slot = slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  div_cnt <= '0;
    else if (ce) div_cnt <= '0;
    else         div_cnt <= div_cnt + 1'b1;
  end

  // A fetch completing now counts as already queued when deciding whether to fetch again.
  assign data_busy    = (slot == S_DREAD) || (slot == S_DWRITE);
  assign launch_data  = d_req && !data_busy;
  assign push         = ce && (slot == S_FETCH) && !stale && !jmp;
  assign pop          = q_rd && (q_count != '0) && !jmp;
  assign base_count   = jmp ? '0 : q_count;
  assign fill         = {1'b0, base_count} + (CW+1)'(push);
  assign launch_fetch = !launch_data && (fill < (CW+1)'(EFF_DEPTH));
  assign launch_seg   = jmp ? cs : fseg;
  assign launch_off   = jmp ? ip : (push ? foff + 16'd1 : foff);

  always_comb begin
    slot_nxt = slot;
    if (ce) begin
      if (launch_data)       slot_nxt = d_we ? S_DWRITE : S_DREAD;
      else if (launch_fetch) slot_nxt = S_FETCH;
      else                   slot_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot <= S_IDLE;
    else        slot <= slot_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      o       <= '0;
      w       <= 1'b0;
      d_ack   <= 1'b0;
      d_rdata <= '0;
    end else begin
      d_ack <= ce && data_busy;
      if (ce && (slot == S_DREAD)) d_rdata <= i;
      if (ce) begin
        w <= 1'b0;
        if (launch_data) begin
          a <= phys(d_seg, d_off);
          if (d_we) begin
            o <= d_wdata;
            w <= 1'b1;
          end
        end else if (launch_fetch) begin
          a <= phys(launch_seg, launch_off);
        end
      end
    end
  end

  // A fetch overtaken by jmp still finishes on the bus; stale marks its byte for discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fseg  <= 16'hFFFF;
      foff  <= 16'h0000;
      stale <= 1'b0;
    end else begin
      if (jmp) begin
        fseg <= cs;
        foff <= ip;
      end else if (push) begin
        foff <= foff + 16'd1;
      end
      if (ce)                         stale <= 1'b0;
      else if (jmp && slot == S_FETCH) stale <= 1'b1;
    end
  end

  always_comb begin
    q_nxt = qvec;
    widx  = q_count;
    if (pop) begin
      q_nxt = qvec >> 8;
      widx  = q_count - CW'(1);
    end
    if (push) q_nxt[widx*8 +: 8] = i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qvec    <= '0;
      q_count <= '0;
    end else if (jmp) begin
      q_count <= '0;
    end else begin
      qvec    <= q_nxt;
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  assign q_data  = qvec[7:0];
  assign q_valid = (q_count != '0);

endmodule

// File: tb/tb_cpu_biu.sv
// Self-checking bench for cpu_biu: memory model returns a hash of the address,
// code stream and data accesses are checked against a seg:off reference model.
module tb_cpu_biu;
  localparam int DIV = 4;
`ifdef CPU_BIU_PREFETCH_EN
  localparam int EXP_DEPTH = 6;
`else
  localparam int EXP_DEPTH = 1;
`endif

  logic        clk, rst_n;
  logic        ce_out;
  logic [19:0] a;
  logic [7:0]  i, o;
  logic        w;
  logic        jmp;
  logic [15:0] cs, ip;
  logic [7:0]  q_data;
  logic        q_valid;
  logic [2:0]  q_count;
  logic        q_rd;
  logic        d_req, d_we;
  logic [15:0] d_seg, d_off;
  logic [7:0]  d_wdata;
  logic        d_ack;
  logic [7:0]  d_rdata;
  logic [1:0]  dbg_slot;

  int checks = 0;
  int errors = 0;

  logic [28:0] exp_q[$];
  logic [15:0] mseg = 16'hFFFF;
  logic [15:0] moff = 16'h0000;
  logic        req_on = 1'b0;
  int          req_clks = 0;

  cpu_biu #(.ADDR_W(20), .QUEUE_DEPTH(6), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .ce_out(ce_out), .a(a), .i(i), .o(o), .w(w),
    .jmp(jmp), .cs(cs), .ip(ip), .q_data(q_data), .q_valid(q_valid),
    .q_count(q_count), .q_rd(q_rd), .d_req(d_req), .d_we(d_we),
    .d_seg(d_seg), .d_off(d_off), .d_wdata(d_wdata), .d_ack(d_ack),
    .d_rdata(d_rdata), .dbg_slot(dbg_slot)
  );

  function automatic logic [7:0] memf(input logic [19:0] ad);
    return ad[7:0] ^ ad[19:12] ^ ad[11:4];
  endfunction

  function automatic logic [19:0] phys(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

  assign i = memf(a);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_tick();
    bit got = 1'b0;
    for (int k = 0; k < 2*DIV; k++) begin
      @(negedge clk);
      if (ce_out) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("ce_wait");
    @(posedge clk);
    #1;
  endtask

  // One clk of queue-side stimulus; the popped byte is checked against the code stream.
  task automatic cyc(input logic rd, input logic jp, input logic [15:0] jcs, input logic [15:0] jip);
    @(negedge clk);
    if (jp) begin
      mseg = jcs;
      moff = jip;
    end else if (rd && q_valid) begin
      chk("q_data_stream", {24'h0, q_data}, {24'h0, memf(phys(mseg, moff))});
      moff = moff + 16'd1;
    end
    q_rd = rd;
    jmp  = jp;
    cs   = jcs;
    ip   = jip;
  endtask

  // Data requester step, called right after a negedge.
  task automatic dstep(input logic want, input logic we, input logic [15:0] seg,
                       input logic [15:0] off, input logic [7:0] wd);
    logic [19:0] ad;
    if (req_on) begin
      req_clks++;
      if (d_ack) begin
        chk("d_latency", {31'h0, (req_clks <= 2*DIV)}, 32'd1);
        d_req  = 1'b0;
        req_on = 1'b0;
      end else if (req_clks > 2*DIV + 2) begin
        fail_now("d_ack_wait");
        d_req  = 1'b0;
        req_on = 1'b0;
      end
    end else if (want) begin
      ad       = phys(seg, off);
      d_req    = 1'b1;
      d_we     = we;
      d_seg    = seg;
      d_off    = off;
      d_wdata  = wd;
      req_on   = 1'b1;
      req_clks = 0;
      exp_q.push_back({we, ad, we ? wd : memf(ad)});
    end
  endtask

  task automatic data_txn(input logic we, input logic [15:0] seg, input logic [15:0] off,
                          input logic [7:0] wd);
    cyc(1'b0, 1'b0, 16'h0, 16'h0);
    dstep(1'b1, we, seg, off, wd);
    for (int k = 0; k < 4*DIV && req_on; k++) begin
      cyc(1'b0, 1'b0, 16'h0, 16'h0);
      dstep(1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int          clk_since = 0;
  bit          seen_ce = 1'b0;
  bit          w_on = 1'b0;
  int          w_len = 0;
  logic [19:0] w_a;
  logic [7:0]  w_o;
  logic        ack_prev = 1'b0;

  initial begin
    logic [28:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        seen_ce  = 1'b0;
        w_on     = 1'b0;
        ack_prev = 1'b0;
      end else begin
        clk_since++;
        if (ce_out) begin
          if (seen_ce) chk("ce_period", clk_since, DIV);
          seen_ce   = 1'b1;
          clk_since = 0;
        end
        chk("q_count_max", {31'h0, (int'(q_count) <= EXP_DEPTH)}, 32'd1);
        if (w) begin
          if (!w_on) begin
            w_a   = a;
            w_o   = o;
            w_len = 0;
            w_on  = 1'b1;
          end
          w_len++;
        end
        if (d_ack) begin
          chk("d_ack_width", {31'h0, ack_prev}, 32'd0);
          if (exp_q.size() == 0) begin
            fail_now("unexpected_d_ack");
          end else begin
            e = exp_q.pop_front();
            if (e[28]) begin
              chk("wr_strobe", {31'h0, w_on}, 32'd1);
              chk("wr_addr", {12'h0, w_a}, {12'h0, e[27:8]});
              chk("wr_data", {24'h0, w_o}, {24'h0, e[7:0]});
              chk("wr_len", w_len, DIV);
              w_on = 1'b0;
            end else begin
              chk("rd_data", {24'h0, d_rdata}, {24'h0, e[7:0]});
            end
          end
        end
        ack_prev = d_ack;
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    bit ack_seen;
    rst_n = 1'b0; jmp = 1'b0; cs = '0; ip = '0; q_rd = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_seg = '0; d_off = '0; d_wdata = '0;
    repeat (5) @(negedge clk);
    chk("rst_a", {12'h0, a}, 32'h0);
    chk("rst_o", {24'h0, o}, 32'h0);
    chk("rst_w", {31'h0, w}, 32'h0);
    chk("rst_ce", {31'h0, ce_out}, 32'h0);
    chk("rst_q_valid", {31'h0, q_valid}, 32'h0);
    chk("rst_q_count", {29'h0, q_count}, 32'h0);
    chk("rst_q_data", {24'h0, q_data}, 32'h0);
    chk("rst_d_ack", {31'h0, d_ack}, 32'h0);
    chk("rst_d_rdata", {24'h0, d_rdata}, 32'h0);
    rst_n = 1'b1;

    // Reset-vector fetch and queue fill.
    wait_tick();
    chk("first_addr", {12'h0, a}, 32'hFFFF0);
    repeat (EXP_DEPTH) wait_tick();
    chk("fill_count", {29'h0, q_count}, EXP_DEPTH);
    chk("fill_head", {24'h0, q_data}, {24'h0, memf(20'hFFFF0)});
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      chk("full_count", {29'h0, q_count}, EXP_DEPTH);
      chk("full_no_w", {31'h0, w}, 32'h0);
    end

    // Data write while the queue is full, then fetch must resume.
    data_txn(1'b1, 16'h1234, 16'h0005, 8'h5A);
    chk("full_after_wr", {29'h0, q_count}, EXP_DEPTH);
    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (EXP_DEPTH + 2) wait_tick();
    chk("refill_count", {29'h0, q_count}, EXP_DEPTH);

    // Offset wrap inside segment F000.
    cyc(1'b0, 1'b1, 16'hF000, 16'hFFFF);
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0);

    // jmp while a fetch is in flight: stale byte dropped.
    wait_tick();
    jmp = 1'b1; cs = 16'h2000; ip = 16'h0000;
    @(posedge clk); #1;
    jmp = 1'b0;
    wait_tick();
    jmp = 1'b1; cs = 16'h0000; ip = 16'h0100;
    mseg = 16'h0000; moff = 16'h0100;
    @(posedge clk); #1;
    jmp = 1'b0;
    chk("jmp_flush", {29'h0, q_count}, 32'h0);
    wait_tick();
    chk("jmp_addr", {12'h0, a}, 32'h00100);
    wait_tick();
    chk("jmp_count", {29'h0, q_count}, 32'h1);
    chk("jmp_head", {24'h0, q_data}, {24'h0, memf(20'h00100)});

    // Read with 20-bit address wrap.
    data_txn(1'b0, 16'hFFFF, 16'h0010, 8'h00);

    // Randomised mix of pops, jumps and data accesses.
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] jip;
      jip = ($urandom_range(0, 1) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, 16'($urandom), jip);
      dstep($urandom_range(0, 15) == 0, 1'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
    end
    for (int k = 0; k < 4*DIV && req_on; k++) begin
      cyc(1'b0, 1'b0, 16'h0, 16'h0);
      dstep(1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    end
    cyc(1'b0, 1'b0, 16'h0, 16'h0);

    // Reset asserted in the middle of a write slot.
    dstep(1'b1, 1'b1, 16'h0ABC, 16'h0003, 8'hC3);
    for (int k = 0; k < 3*DIV; k++) begin
      cyc(1'b0, 1'b0, 16'h0, 16'h0);
      if (w) break;
    end
    chk("w_before_rst", {31'h0, w}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_w", {31'h0, w}, 32'h0);
    chk("midrst_ack", {31'h0, d_ack}, 32'h0);
    chk("midrst_a", {12'h0, a}, 32'h0);
    d_req = 1'b0; req_on = 1'b0;
    mseg = 16'hFFFF; moff = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 1'b0;
    for (int k = 0; k < 3*DIV; k++) begin
      @(negedge clk);
      if (d_ack) ack_seen = 1'b1;
    end
    chk("no_ack_after_rst", {31'h0, ack_seen}, 32'h0);
    chk("w_after_rst", {31'h0, w}, 32'h0);
    wait_tick();
    chk("refetch_addr", {12'h0, a}, 32'hFFFF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
